// File: rtl/rgb_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_seq_pkg : shared types and helpers for the RGB LED sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rgb_seq_pkg;

  localparam int DUTY_W     = 8;
  localparam int HOLD_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Hold is stored at the widest supported width; unused upper bits stay zero.
  typedef struct packed {
    logic [DUTY_W-1:0]     red;
    logic [DUTY_W-1:0]     grn;
    logic [DUTY_W-1:0]     blu;
    logic [HOLD_W_MAX-1:0] hold;
  } step_t;

  function automatic int STEP_IDX_W(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_pwm_channel : period-aligned duty latch and registered compare   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rgb_pwm_channel
  import rgb_seq_pkg::*;
(
  input  logic              int_osc,
  input  logic              rstn,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              enable,
  output logic              pwm
);

  logic [DUTY_W-1:0] r_duty;
  logic              r_pwm;

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (load) begin
        r_duty <= duty;
      end
      r_pwm <= enable && (pwm_cnt < r_duty);
    end
  end

  assign pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/rgb_led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_led_sequencer : loops a programmable RGB duty/hold pattern table |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rgb_led_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int CLK_DIV = 188,
  parameter int STEPS   = 4,
  parameter int HOLD_W  = 16
) (
  input  logic                         int_osc,
  input  logic                         rstn,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [STEP_IDX_W(STEPS)-1:0] cfg_addr,
  input  logic [DUTY_W-1:0]            cfg_red,
  input  logic [DUTY_W-1:0]            cfg_grn,
  input  logic [DUTY_W-1:0]            cfg_blu,
  input  logic [HOLD_W-1:0]            cfg_hold,
  input  logic                         run,
  output logic                         busy,
  output logic [STEP_IDX_W(STEPS)-1:0] step_idx,
  output logic                         frame_done,
  output logic                         red_pwm,
  output logic                         grn_pwm,
  output logic                         blu_pwm
);

  localparam int                    c_idx_w      = STEP_IDX_W(STEPS);
  localparam int                    c_presc_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_presc_w-1:0]  c_presc_last = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_last_idx   = c_idx_w'(STEPS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_run;
  logic [c_presc_w-1:0]  r_presc;
  logic [DUTY_W-1:0]     r_pwm_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [c_idx_w-1:0]    r_step_idx;
  logic                  r_frame_done;
  step_t                 r_table [STEPS];

  logic                  w_active;
  logic                  w_ready;
  logic                  w_start;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_step_end;
  logic                  w_load;
  logic [HOLD_W_MAX-1:0] w_cur_hold;
  logic [HOLD_W_MAX-1:0] w_hold_m1;
  logic [c_idx_w-1:0]    w_rd_idx;
  step_t                 w_entry;

  assign w_active   = (r_state != IDLE);
  assign w_start    = (r_state == IDLE) && r_run;
  assign w_tick     = w_active && (r_presc == c_presc_last);
  assign w_wrap     = w_tick && (r_pwm_cnt == {DUTY_W{1'b1}});
  assign w_cur_hold = r_table[r_step_idx].hold;
  // A hold of 0 behaves like 1: the step still lasts one full period.
  assign w_hold_m1  = (w_cur_hold == '0) ? '0 : w_cur_hold - 1'b1;
  assign w_step_end = (r_state == RUN) && w_wrap && (HOLD_W_MAX'(r_hold_cnt) == w_hold_m1);
  assign w_load     = w_start || (w_active && w_wrap);

  // Duties for the new period come from the step that period belongs to.
  always_comb begin
    w_rd_idx = r_step_idx;
    if (w_start) begin
      w_rd_idx = '0;
    end else if (w_step_end) begin
      w_rd_idx = r_step_idx + 1'b1;
    end
  end

  assign w_entry = r_table[w_rd_idx];

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (r_run) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!r_run) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_run) begin
          w_state_nxt = RUN;
        end else if (w_wrap) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      r_run        <= 1'b0;
      r_presc      <= '0;
      r_pwm_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_step_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_run        <= run;
      r_frame_done <= w_step_end && (r_step_idx == c_last_idx);
      if (w_start) begin
        r_presc    <= '0;
        r_pwm_cnt  <= '0;
        r_hold_cnt <= '0;
        r_step_idx <= '0;
      end else if (w_active) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
        // Periods completed while stopping are not counted toward the hold.
        if (w_step_end) begin
          r_hold_cnt <= '0;
          r_step_idx <= r_step_idx + 1'b1;
        end else if ((r_state == RUN) && w_wrap) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge int_osc or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) begin
        r_table[i] <= '0;
      end
    end else if (cfg_valid && w_ready) begin
      r_table[cfg_addr] <= '{red: cfg_red, grn: cfg_grn, blu: cfg_blu,
                             hold: HOLD_W_MAX'(cfg_hold)};
    end
  end

  rgb_pwm_channel u_red (
    .int_osc (int_osc),
    .rstn    (rstn),
    .load    (w_load),
    .duty    (w_entry.red),
    .pwm_cnt (r_pwm_cnt),
    .enable  (w_active),
    .pwm     (red_pwm)
  );

  rgb_pwm_channel u_grn (
    .int_osc (int_osc),
    .rstn    (rstn),
    .load    (w_load),
    .duty    (w_entry.grn),
    .pwm_cnt (r_pwm_cnt),
    .enable  (w_active),
    .pwm     (grn_pwm)
  );

  rgb_pwm_channel u_blu (
    .int_osc (int_osc),
    .rstn    (rstn),
    .load    (w_load),
    .duty    (w_entry.blu),
    .pwm_cnt (r_pwm_cnt),
    .enable  (w_active),
    .pwm     (blu_pwm)
  );

  assign cfg_ready  = w_ready;
  assign busy       = w_active;
  assign step_idx   = r_step_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
- Drives the three PWM inputs of the on-chip RGB LED driver (red, green, blue) from a small programmable pattern table.
- Each table step holds one 8-bit duty per colour and a hold time in PWM periods. The block steps through the table in a loop while run is high.
- It sits between user logic (cfg write port, run/stop) and the RGB LED driver, and replaces ad-hoc counter-bit decoding of the PWM pins.

Parameters:
- CLK_DIV, 188, int_osc cycles per PWM counter tick. The PWM period is CLK_DIV*256 cycles, about 1 kHz at 48 MHz.
- STEPS, 4, number of pattern table entries. Must be a power of two, 2..16.
- HOLD_W, 16, width of the per-step hold count.

Ports:
- int_osc  in  1  clock, from the internal HF oscillator
- rstn  in  1  asynchronous, active-low reset
- cfg_valid  in  1  table write request
- cfg_ready  out  1  table write accepted when valid&ready
- cfg_addr  in  log2(STEPS)  table entry index
- cfg_red  in  8  red duty, 0..255
- cfg_grn  in  8  green duty
- cfg_blu  in  8  blue duty
- cfg_hold  in  HOLD_W  PWM periods to hold the step
- run  in  1  level: 1 = play pattern, 0 = stop
- busy  out  1  state != IDLE
- step_idx  out  log2(STEPS)  current step
- frame_done  out  1  one-cycle pulse when the last step finishes
- red_pwm  out  1  to driver RGB0PWM
- grn_pwm  out  1  to driver RGB1PWM
- blu_pwm  out  1  to driver RGB2PWM

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE.
  - All table entries = 0 (duties 0, hold 0).
  - Prescaler, pwm_cnt, hold_cnt and step_idx = 0.
  - All pwm outputs, busy and frame_done = 0.
  - cfg_ready = 1.
- Reset mid-operation forces all pwm outputs low immediately (asynchronously). The table is cleared.
- FSM states are IDLE, RUN and STOP.
  - IDLE to RUN: on run=1 sampled. step_idx, prescaler, pwm_cnt and hold_cnt clear, and entry 0's duties are latched.
  - RUN to STOP: on run=0 sampled.
  - STOP to IDLE: at the end of the current PWM period, when pwm_cnt wraps 255 to 0 on a tick.
  - STOP to RUN: if run=1 is sampled before that wrap. The pattern continues with no restart.
- cfg_ready = 1 only in IDLE. A write (valid&ready) updates the addressed entry at the clock edge. Writes in RUN or STOP are stalled, never dropped.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - tick = 1 for the cycle in which it equals CLK_DIV-1.
  - pwm_cnt increments by 1 on each tick and wraps 255 to 0 naturally.
- Duty latching:
  - Each channel's duty register loads from the current step's entry only when pwm_cnt wraps (period start), or on IDLE to RUN.
  - There is no mid-period glitch.
- Outputs are registered: chan_pwm <= (state != IDLE) && (pwm_cnt < duty_q).
  - duty 0 gives a constant 0.
  - duty 255 gives 255/256 high.
- Latency:
  - run is sampled high at edge N.
  - At edge N+1 the state is RUN.
  - At edge N+2 red_pwm goes high if entry 0 red > 0.
- Hold and step advance:
  - hold_cnt counts completed PWM periods.
  - A step ends when hold_cnt reaches max(hold,1)-1 and the period wraps. hold=0 is treated as 1.
  - On step end: hold_cnt = 0 and step_idx increments, wrapping STEPS-1 to 0.
  - frame_done pulses for 1 cycle, in the same cycle as the STEPS-1 to 0 transition.
- STOP does not advance the step. hold_cnt freezes at the period end, then the block enters IDLE.
- On return to IDLE, the pwm outputs are 0 from the cycle after the state reaches IDLE. step_idx keeps its value. A subsequent run restarts at step 0.
- Simultaneous events: a step-end wrap and run falling in the same cycle means the step advances and the FSM then enters STOP.

Decomposition:
- Package rgb_seq_pkg holds:
  - DUTY_W = 8
  - state enum: IDLE, RUN, STOP
  - step_t struct: red, grn, blu, hold
  - STEP_IDX_W function, log2(STEPS)
- Sub-module rgb_pwm_channel is instantiated 3 times. It contains the duty latch and registered compare, with inputs int_osc, rstn, load, duty, pwm_cnt and enable.

Test Plan (CLK_DIV=2, so a 512-cycle period):
- Reset, then check all outputs are 0 and cfg_ready=1. Write entry0 = {R=128,G=0,B=255,hold=1} and set run=1. Expect:
  - red_pwm high for 256 of every 512 cycles.
  - grn_pwm constantly 0.
  - blu_pwm low for exactly 2 cycles per period.
  - first red_pwm high 2 cycles after run.
- Program entries 0..3 with hold=3 and distinct red duties. Expect:
  - step_idx advancing every 1536 cycles.
  - frame_done pulsing once per 6144 cycles, coincident with step_idx going 3 to 0.
- Drop run mid-period at pwm_cnt=100. Expect:
  - busy stays 1 until pwm_cnt wraps.
  - then IDLE, with outputs 0 and busy 0.
  - re-raise run within that window and check the step continues with no restart.
- Assert cfg_valid in RUN. Expect cfg_ready=0 and the write held; after stop it completes, and the next run shows the new duty.
- Set hold=0 on entry 1. Expect step 1 to last exactly 512 cycles.
- Pulse rstn low mid-RUN. Expect all pwm outputs 0 within the same cycle (asynchronous), the table cleared, and a rerun producing constant 0 outputs.
